// File: rtl/reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter
//
// Round-robin arbiter and write sequencer for one shared DW-bit register.
// NREQ requesters compete for write access. The winner holds the grant for
// up to HOLD writes, or until it drops its request. The grant then rotates
// to the next requester at or after the one following the previous winner.
// Re-arbitration happens in the same edge as the release, so a busy bus
// has no idle cycles between grants.
//
// Optional build macro:
//   INVERT_STORE_EN - the register stores ~wdata instead of wdata.
//                     The reset value and all timing are unchanged.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   req      in   [NREQ]     level-sensitive request per requester
//   wdata    in   [NREQ*DW]  packed write data, requester i at [i*DW +: DW]
//   gnt      out  [NREQ]     registered one-hot grant (or zero)
//   busy     out             high while in the GRANT state
//   q        out  [DW]       shared register contents
//   q_valid  out             one-cycle pulse after each write
//   owner    out  [clog2]    index of the requester that made the last write
// ---------------------------------------------------------------------------
module reg_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int HOLD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        wdata,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic [DW-1:0]             q,
    output logic                      q_valid,
    output logic [$clog2(NREQ)-1:0]   owner
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   widx_q, widx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_d;
    logic [DW-1:0]   q_d;
    logic            q_valid_d;
    logic [IW-1:0]   owner_d;
    logic            release_now;
    logic [DW-1:0]   store_data;

    // First set request bit at or after index p, wrapping modulo NREQ.
    // Only called when at least one request bit is set.
    function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [IW-1:0]   p);
        logic found;
        int   idx;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Only the current grant holder's data slice is ever routed to the
    // register, so non-granted wdata is never sampled.
`ifdef INVERT_STORE_EN
    assign store_data = ~wdata[widx_q*DW +: DW];
`else
    assign store_data = wdata[widx_q*DW +: DW];
`endif

    assign busy = (state_q == GRANT);

    // Next-state logic: arbitration out of IDLE, write/count/release while
    // granted, and same-edge re-arbitration on release using the advanced
    // rotation pointer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        widx_d      = widx_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt;
        q_d         = q;
        q_valid_d   = 1'b0;
        owner_d     = owner;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    widx_d  = pick(req, ptr_q);
                    gnt_d   = onehot(widx_d);
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                if (req[widx_q]) begin
                    q_d       = store_data;
                    owner_d   = widx_q;
                    q_valid_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(HOLD - 1)) begin
                        release_now = 1'b1;
                    end
                end else begin
                    // An idle holder loses the grant after a single cycle.
                    release_now = 1'b1;
                end

                if (release_now) begin
                    ptr_d = (widx_q == IW'(NREQ - 1)) ? '0 : widx_q + IW'(1);
                    if (|req) begin
                        widx_d = pick(req, ptr_d);
                        gnt_d  = onehot(widx_d);
                        cnt_d  = '0;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any grant in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            widx_q  <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            q       <= q_d;
            q_valid <= q_valid_d;
            owner   <= owner_d;
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_share_arbiter
//
// Self-checking bench for reg_share_arbiter with NREQ=4, DW=8, HOLD=2.
// Directed scenarios check the documented grant sequences; a randomized
// run compares every cycle against a reference model of the arbitration
// rules kept in this file.
// ---------------------------------------------------------------------------
module tb_reg_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int HOLD = 2;
    localparam int IW   = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic [DW-1:0]       q;
    logic                q_valid;
    logic [IW-1:0]       owner;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who holds the grant, how many writes it has made,
    // where the next search starts, and what the register shows.
    bit          m_active;
    int          m_w;
    int          m_ptr;
    int          m_cnt;
    logic [DW-1:0] m_q;
    bit          m_qv;
    int          m_owner;

    reg_share_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef INVERT_STORE_EN
        return ~d;
`else
        return d;
`endif
    endfunction

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_active) g[m_w] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_w      = 0;
        m_ptr    = 0;
        m_cnt    = 0;
        m_q      = '0;
        m_qv     = 1'b0;
        m_owner  = 0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs the
    // DUT samples at the same edge.
    task automatic model_edge();
        bit rel;
        rel = 1'b0;
        if (!m_active) begin
            m_qv = 1'b0;
            if (req != '0) begin
                m_w      = first_from(req, m_ptr);
                m_cnt    = 0;
                m_active = 1'b1;
            end
        end else begin
            if (req[m_w]) begin
                m_q     = stored(wdata[m_w*DW +: DW]);
                m_owner = m_w;
                m_qv    = 1'b1;
                m_cnt   = m_cnt + 1;
                rel     = (m_cnt == HOLD);
            end else begin
                m_qv = 1'b0;
                rel  = 1'b1;
            end
            if (rel) begin
                m_ptr = (m_w + 1) % NREQ;
                if (req != '0) begin
                    m_w   = first_from(req, m_ptr);
                    m_cnt = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_wdata();
        for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Reset holds everything at zero even with all requests asserted, and
    // the first grant after release goes to requester 0.
    task automatic test_reset();
        rst = 1'b0;
        req = '1;
        rand_wdata();
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({gnt, busy, q, q_valid} !== '0)
                $display("[TB] FAIL reset_hold: got gnt=%b busy=%b q=%h qv=%b, want all 0", gnt, busy, q, q_valid);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1)
            $display("[TB] FAIL reset_first_grant: got gnt=%b busy=%b, want gnt=0001 busy=1", gnt, busy);
        else n_pass++;
    endtask

    // A lone requester is re-granted back-to-back and writes every cycle.
    task automatic test_lone_requester();
        do_reset();
        req = 4'b0100;
        rand_wdata();
        wdata[2*DW +: DW] = 8'hA5;
        step();
        n_checks++;
        if (gnt !== 4'b0100 || q_valid !== 1'b0)
            $display("[TB] FAIL lone_grant: got gnt=%b qv=%b, want gnt=0100 qv=0", gnt, q_valid);
        else n_pass++;
        repeat (6) begin
            step();
            n_checks++;
            if ({gnt, q, owner, q_valid} !== {4'b0100, stored(8'hA5), 2'd2, 1'b1})
                $display("[TB] FAIL lone_write: got gnt=%b q=%h owner=%0d qv=%b, want gnt=0100 q=%h owner=2 qv=1",
                         gnt, q, owner, q_valid, stored(8'hA5));
            else n_pass++;
        end
    endtask

    // All requesters active: order 0,1,2,3,0 with HOLD writes each and no gap.
    task automatic test_round_robin();
        int eo;
        logic [NREQ-1:0] eg;
        do_reset();
        req   = 4'b1111;
        wdata = 32'h44332211;
        step();
        n_checks++;
        if (gnt !== 4'b0001)
            $display("[TB] FAIL rr_first: got gnt=%b, want 0001", gnt);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            step();
            eo = (k / 2) % NREQ;
            eg = '0;
            eg[((k + 1) / 2) % NREQ] = 1'b1;
            n_checks++;
            if ({gnt, busy, q, q_valid, owner} !== {eg, 1'b1, stored(wdata[eo*DW +: DW]), 1'b1, IW'(eo)})
                $display("[TB] FAIL rr_seq%0d: got gnt=%b busy=%b q=%h qv=%b owner=%0d, want gnt=%b busy=1 q=%h qv=1 owner=%0d",
                         k, gnt, busy, q, q_valid, owner, eg, stored(wdata[eo*DW +: DW]), eo);
            else n_pass++;
        end
    endtask

    // Dropping the request releases at the next edge; q keeps the old value.
    task automatic test_drop_release();
        logic [DW-1:0] w1, w2;
        do_reset();
        w1 = DW'($urandom);
        w2 = ~w1;
        rand_wdata();
        wdata[1*DW +: DW] = w1;
        wdata[2*DW +: DW] = w2;
        req = 4'b0110;
        step();
        n_checks++;
        if (gnt !== 4'b0010)
            $display("[TB] FAIL drop_grant1: got gnt=%b, want 0010", gnt);
        else n_pass++;
        step();
        n_checks++;
        if ({q, owner, q_valid} !== {stored(w1), 2'd1, 1'b1})
            $display("[TB] FAIL drop_write1: got q=%h owner=%0d qv=%b, want q=%h owner=1 qv=1", q, owner, q_valid, stored(w1));
        else n_pass++;
        req = 4'b0100;
        step();
        n_checks++;
        if ({gnt, q, owner, q_valid} !== {4'b0100, stored(w1), 2'd1, 1'b0})
            $display("[TB] FAIL drop_release: got gnt=%b q=%h owner=%0d qv=%b, want gnt=0100 q=%h owner=1 qv=0",
                     gnt, q, owner, q_valid, stored(w1));
        else n_pass++;
        step();
        n_checks++;
        if ({q, owner, q_valid} !== {stored(w2), 2'd2, 1'b1})
            $display("[TB] FAIL drop_write2: got q=%h owner=%0d qv=%b, want q=%h owner=2 qv=1", q, owner, q_valid, stored(w2));
        else n_pass++;
    endtask

    // Reset between edges clears outputs with no clock; arbitration restarts at 0.
    task automatic test_async_reset();
        do_reset();
        req = 4'b1111;
        rand_wdata();
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({gnt, busy, q, q_valid, owner} !== '0)
            $display("[TB] FAIL async_reset: got gnt=%b busy=%b q=%h qv=%b owner=%0d, want all 0",
                     gnt, busy, q, q_valid, owner);
        else n_pass++;
        @(negedge clk);
        req = 4'b1010;
        rst = 1'b1;
        step();
        n_checks++;
        if (gnt !== 4'b0010)
            $display("[TB] FAIL async_regrant: got gnt=%b, want 0010", gnt);
        else n_pass++;
    endtask

    // Random requests, data and occasional mid-cycle resets against the model.
    task automatic test_random();
        logic [NREQ-1:0] eg;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = NREQ'($urandom) & NREQ'($urandom | $urandom);
            rand_wdata();
            step();
            eg = exp_gnt();
            n_checks++;
            if ({gnt, busy, q, q_valid, owner} !== {eg, m_active, m_q, m_qv, IW'(m_owner)})
                $display("[TB] FAIL rand_c%0d: got gnt=%b busy=%b q=%h qv=%b owner=%0d, want gnt=%b busy=%b q=%h qv=%b owner=%0d",
                         c, gnt, busy, q, q_valid, owner, eg, m_active, m_q, m_qv, m_owner);
            else n_pass++;
            n_checks++;
            if (!$onehot0(gnt))
                $display("[TB] FAIL rand_onehot_c%0d: got gnt=%b, want zero or one-hot", c, gnt);
            else n_pass++;
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                model_reset();
                n_checks++;
                if ({gnt, busy, q, q_valid, owner} !== '0)
                    $display("[TB] FAIL rand_reset_c%0d: got gnt=%b busy=%b q=%h qv=%b owner=%0d, want all 0",
                             c, gnt, busy, q, q_valid, owner);
                else n_pass++;
                @(negedge clk);
                rst = 1'b1;
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        req   = '0;
        wdata = '0;
        model_reset();
        $display("[TB] starting reg_share_arbiter bench");
        test_reset();
        test_lone_requester();
        test_round_robin();
        test_drop_release();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
